// File: rtl/maxpool2x2_float.sv
// ============================================================================
// Module   : maxpool2x2_float
// Purpose  : Streaming 2x2 stride-2 max-pool on IEEE-754 single-precision
//            pixels. Optional end-of-frame check enabled by MAXPOOL_LAST_CHK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxpool2x2_float #(
    parameter int IMG_W = 416,
    parameter int IMG_H = 416,
    parameter int COL_W = 9,
    parameter int ROW_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_float,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_last
`ifdef MAXPOOL_LAST_CHK_EN
    ,
    input  logic        in_last,
    output logic        frame_err
`endif
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [31:0]      pair;
    logic [31:0]      line_buf [IMG_W/2];

    logic             accept;
    logic             at_end;
    logic             err;
    logic             restart;
    logic             load;
    logic [COL_W-2:0] lb_idx;
    logic [31:0]      pair_max;
    logic [31:0]      win_max;

    // Sign-magnitude compare: no arithmetic, ties keep operand a.
    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31] ? b : a;
        else if (!a[31])
            return (b[30:0] > a[30:0]) ? b : a;
        else
            return (b[30:0] < a[30:0]) ? b : a;
    endfunction

    assign in_ready = ~(out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign at_end   = (row == ROW_LAST) && (col == COL_LAST);
    assign lb_idx   = col[COL_W-1:1];
    assign pair_max = fmax(pair, in_float);
    assign win_max  = fmax(line_buf[lb_idx], pair_max);

`ifdef MAXPOOL_LAST_CHK_EN
    assign err     = accept & (in_last != at_end);
    assign restart = accept & in_last;
`else
    assign err     = 1'b0;
    assign restart = 1'b0;
`endif

    // A mismatched beat never produces a result; the window it belonged to is lost.
    assign load = accept & col[0] & row[0] & ~err;

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            pair      <= '0;
            out_valid <= 1'b0;
            out_float <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (err)
                    pair <= '0;
                else if (!col[0])
                    pair <= in_float;

                if (restart || col == COL_LAST) begin
                    col <= '0;
                    row <= (restart || row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_float <= win_max;
                out_last  <= at_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Even-row horizontal maxima; read back on the following odd row only.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0])
            line_buf[lb_idx] <= pair_max;
    end

`ifdef MAXPOOL_LAST_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            frame_err <= 1'b0;
        else if (err)
            frame_err <= 1'b1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_maxpool2x2_float.sv
// ============================================================================
// Module   : tb_maxpool2x2_float
// Purpose  : Scoreboard bench for maxpool2x2_float on a 4x2 frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_maxpool2x2_float;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_float = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_float;
    logic        out_last;
`ifdef MAXPOOL_LAST_CHK_EN
    logic        in_last = 1'b0;
    logic        frame_err;
    bit          force_last = 0;
`endif

    maxpool2x2_float #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(2), .ROW_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_float  (in_float),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_last  (out_last)
`ifdef MAXPOOL_LAST_CHK_EN
        ,
        .in_last   (in_last),
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           out_count = 0;
    int           ready_mode = 0;   // 0: ready high, 1: ready low, 2: random
    bit           model_off = 0;
    logic [32:0]  sb [$];
    logic [31:0]  fb [IMG_H][IMG_W];
    int           tcol = 0;
    int           trow = 0;
    time          t_accept = 0;

    // Monotonic key: unsigned order of keys equals float order (-0 < +0).
    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] fmax_ref(input logic [31:0] a, input logic [31:0] b);
        return (okey(b) > okey(a)) ? b : a;
    endfunction

    task automatic model_accept(input logic [31:0] d);
        logic [31:0] m;
        fb[trow][tcol] = d;
        if ((tcol % 2 == 1) && (trow % 2 == 1)) begin
            m = fmax_ref(fmax_ref(fb[trow-1][tcol-1], fb[trow-1][tcol]),
                         fmax_ref(fb[trow][tcol-1], fb[trow][tcol]));
            sb.push_back({(trow == IMG_H-1 && tcol == IMG_W-1), m});
        end
        if (tcol == IMG_W-1) begin
            tcol = 0;
            trow = (trow == IMG_H-1) ? 0 : trow + 1;
        end else begin
            tcol = tcol + 1;
        end
    endtask

    task automatic send_pixel(input logic [31:0] d);
        int  waited = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk); #1;
            in_valid = 1'b1;
            in_float = d;
`ifdef MAXPOOL_LAST_CHK_EN
            in_last = force_last | (trow == IMG_H-1 && tcol == IMG_W-1);
`endif
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                t_accept = $time;
                done = 1;
                if (!model_off) model_accept(d);
            end else if (++waited > 50) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", in_ready);
                in_valid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        tcol = 0;
        trow = 0;
    endtask

    // Output side: drives out_ready, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        logic [32:0] exp;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (!rst && out_valid && out_ready) begin
            out_count++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got last=%0b data=%h, required none", out_last, out_float);
            end else begin
                exp = sb.pop_front();
                if ({out_last, out_float} !== exp) begin
                    n_fail++;
                    $display("FAIL output: got last=%0b data=%h, required last=%0b data=%h",
                             out_last, out_float, exp[32], exp[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({out_valid, out_last, out_float, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%0b last=%0b data=%h in_ready=%0b, required 0 0 00000000 1",
                     out_valid, out_last, out_float, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] px [8];
        px = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000,
               32'h3F000000, 32'h40400000, 32'h80000000, 32'h00000000};
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            send_pixel(px[i]);
            if (i == 5 || i == 7) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_float !== (i == 5 ? 32'h40400000 : 32'h0)) begin
                    n_fail++;
                    $display("FAIL basic_latency_px%0d: got valid=%0b data=%h, required valid=1 data=%h",
                             i, out_valid, out_float, (i == 5 ? 32'h40400000 : 32'h0));
                end
            end
        end
        wait_drain("basic");
    endtask

    task automatic test_negative();
        logic [31:0] px [8];
        px = '{32'hBF800000, 32'hC0000000, 32'h7F800000, 32'hFF800000,
               32'hC0400000, 32'hBF000000, 32'h80000000, 32'h80000001};
        for (int i = 0; i < 8; i++) send_pixel(px[i]);
        wait_drain("negative");
    endtask

    task automatic test_backpressure();
        int base;
        logic [31:0] px [8];
        px = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000,
               32'h3F000000, 32'h40400000, 32'h80000000, 32'h00000000};
        base = out_count;
        ready_mode = 1;
        for (int i = 0; i < 6; i++) send_pixel(px[i]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_float !== 32'h40400000) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got in_ready=%0b valid=%0b data=%h, required 0 1 40400000",
                         k, in_ready, out_valid, out_float);
            end
            repeat (2) @(negedge clk);
        end
        ready_mode = 0;
        send_pixel(px[6]);
        send_pixel(px[7]);
        wait_drain("backpressure");
        n_tests++;
        if (out_count - base !== 2) begin
            n_fail++;
            $display("FAIL backpressure_count: got %0d outputs, required 2", out_count - base);
        end
    endtask

    task automatic test_back_to_back();
        int  base;
        time t0;
        base = out_count;
        ready_mode = 0;
        for (int i = 0; i < 16; i++) begin
            send_pixel($urandom);
            if (i == 0) t0 = t_accept;
        end
        n_tests++;
        if (t_accept - t0 !== 150) begin
            n_fail++;
            $display("FAIL b2b_gapless: got %0t span for 16 beats, required 150", t_accept - t0);
        end
        wait_drain("b2b");
        n_tests++;
        if (out_count - base !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, required 4", out_count - base);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        for (int i = 0; i < 5; i++) send_pixel(32'h7F000000);
        do_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_valid: got %0b, required 0", out_valid);
        end
        base = out_count;
        for (int i = 0; i < 8; i++) send_pixel(32'h3F800000 + 32'(i));
        wait_drain("midframe");
        n_tests++;
        if (out_count - base !== 2) begin
            n_fail++;
            $display("FAIL midframe_count: got %0d outputs, required 2", out_count - base);
        end
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int i = 0; i < 32; i++) send_pixel($urandom);
        wait_drain("random");
        ready_mode = 0;
    endtask

`ifdef MAXPOOL_LAST_CHK_EN
    task automatic test_last_chk();
        do_reset();
        model_off = 1;
        for (int i = 0; i < 8; i++) begin
            force_last = (i == 5);
            send_pixel(32'h3F800000);
            if (i >= 5) begin
                n_tests++;
                if (frame_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_err_px%0d: got %0b, required 1", i, frame_err);
                end
            end
        end
        force_last = 0;
        do_reset();
        model_off = 0;
        #1;
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_clear: got %0b, required 0", frame_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
`ifdef MAXPOOL_LAST_CHK_EN
        test_last_chk();
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
